// File: rtl/gshare_predictor.sv
// Gshare branch-direction predictor: PHT of saturating counters indexed by PC ^ GHR, swept to weakly-not-taken after reset.
// Optional macro PREDICTOR_GLOBAL_HISTORY_EN: enables the GHR; without it the predictor is pure bimodal.
module gshare_predictor #(
  parameter int INDEX_WIDTH   = 10,
  parameter int COUNTER_WIDTH = 2,
  parameter int HISTORY_WIDTH = 8
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        instrInValid,
  input  logic [31:0] instrAddr,
  output logic        jump,
  input  logic        updateValid,
  input  logic [31:0] updateAddr,
  input  logic        taken,
  output logic        readyOut
);
  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CTR_MIN  = '0;
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
  localparam logic [INDEX_WIDTH-1:0]   LAST_IDX = '1;
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                     r_state;
  logic [INDEX_WIDTH-1:0]   r_init_ptr;
  logic [COUNTER_WIDTH-1:0] r_pht [DEPTH];

  logic [INDEX_WIDTH-1:0]   w_hist;
  logic [INDEX_WIDTH-1:0]   w_pred_idx;
  logic [INDEX_WIDTH-1:0]   w_upd_idx;
  logic [COUNTER_WIDTH-1:0] w_upd_ctr;
  logic [COUNTER_WIDTH-1:0] w_upd_next;
  logic                     w_upd_go;
  logic                     w_unused;

`ifdef PREDICTOR_GLOBAL_HISTORY_EN
  logic [HISTORY_WIDTH-1:0] r_ghr;

  // Commit-order history only; fetch never speculatively shifts it.
  always_ff @(posedge clockIn) begin
    if (resetIn)       r_ghr <= '0;
    else if (w_upd_go) r_ghr <= HISTORY_WIDTH'({r_ghr, taken});
  end

  assign w_hist = INDEX_WIDTH'(r_ghr);
`else
  assign w_hist = '0;
`endif

  assign readyOut   = (r_state == ST_RUN);
  assign w_upd_go   = updateValid & readyOut;
  assign w_pred_idx = instrAddr[INDEX_WIDTH+1:2] ^ w_hist;
  assign w_upd_idx  = updateAddr[INDEX_WIDTH+1:2] ^ w_hist;
  assign w_upd_ctr  = r_pht[w_upd_idx];

  // Prediction reads the pre-update counter: a same-cycle update is not bypassed.
  assign jump = instrInValid & readyOut & r_pht[w_pred_idx][COUNTER_WIDTH-1];

  always_comb begin
    w_upd_next = w_upd_ctr;
    if (taken) begin
      if (w_upd_ctr != CTR_MAX) w_upd_next = w_upd_ctr + 1'b1;
    end else begin
      if (w_upd_ctr != CTR_MIN) w_upd_next = w_upd_ctr - 1'b1;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_ptr <= r_init_ptr + 1'b1;
      if (r_init_ptr == LAST_IDX) r_state <= ST_RUN;
    end
  end

  // PHT has no reset of its own; the sweep rewrites every entry.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      if (r_state == ST_INIT) r_pht[r_init_ptr] <= CTR_INIT;
      else if (w_upd_go)      r_pht[w_upd_idx]  <= w_upd_next;
    end
  end

  assign w_unused = ^{instrAddr[31:INDEX_WIDTH+2], instrAddr[1:0],
                      updateAddr[31:INDEX_WIDTH+2], updateAddr[1:0]};
endmodule
